// File: rtl/history_pkg.sv
// Shared types for the history serializer: depth, index/count types,
// the captured snapshot payload and the frame FSM states.
package history_pkg;

    localparam int unsigned HIST_DEPTH      = 4;
    localparam int unsigned IDX_W           = 2;
    localparam int unsigned CNT_W           = 3;
    // Snapshot values are carried at this width; DATA_W must not exceed it.
    localparam int unsigned HIST_MAX_DATA_W = 32;

    typedef logic [IDX_W-1:0] hist_idx_t;
    typedef logic [CNT_W-1:0] hist_cnt_t;

    typedef struct packed {
        logic [HIST_DEPTH-1:0][HIST_MAX_DATA_W-1:0] vals;
        hist_cnt_t                                   cnt;
    } hist_snap_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } hist_state_e;

    // Number of leading valid entries; anything after the first gap is ignored.
    function automatic hist_cnt_t first_gap(input logic [HIST_DEPTH-1:0] valid);
        hist_cnt_t n;
        logic      stop;
        n    = CNT_W'(HIST_DEPTH);
        stop = 1'b0;
        for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
            if (!stop && !valid[k]) begin
                n    = CNT_W'(k);
                stop = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/hist_snapshot_capture.sv
// Registers the previous input vector, flags a usable change and builds
// the snapshot (values plus leading-valid count) from the live inputs.
module hist_snapshot_capture
    import history_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_i,
    input  logic [HIST_DEPTH-1:0]            valid_i,
    output logic                             evt_c_o,
    output hist_snap_t                       snap_c_o
);

    localparam int unsigned VEC_W = HIST_DEPTH * (DATA_W + 1);

    logic [VEC_W-1:0] live_c;
    logic [VEC_W-1:0] snap_prev_q;

    assign live_c = {valid_i, hist_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_prev_q <= '0;
        end else begin
            snap_prev_q <= live_c;
        end
    end

    // An empty snapshot (entry 0 invalid) never counts as an event.
    always_comb begin
        snap_c_o = '0;
        for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
            snap_c_o.vals[k] = HIST_MAX_DATA_W'(hist_i[k]);
        end
        snap_c_o.cnt = first_gap(valid_i);
        evt_c_o      = (live_c != snap_prev_q) && (snap_c_o.cnt != '0);
    end

endmodule

// File: rtl/history_serializer.sv
// Serializes each changed history snapshot into a valid/ready frame of
// n beats, with a one-deep pending slot and a saturating drop counter.
module history_serializer
    import history_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic [DATA_W-1:0] hist_0,
    input  logic [DATA_W-1:0] hist_1,
    input  logic [DATA_W-1:0] hist_2,
    input  logic [DATA_W-1:0] hist_3,
    input  logic              hist_valid_0,
    input  logic              hist_valid_1,
    input  logic              hist_valid_2,
    input  logic              hist_valid_3,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        m_idx,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy_out,
    output logic [7:0]        drop_cnt_out
);

    localparam int unsigned DROP_W = 8;

    logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_c;
    logic [HIST_DEPTH-1:0]             valid_c;
    logic                              evt_c;
    hist_snap_t                        snap_c;

    hist_state_e       state_q, state_d;
    hist_snap_t        frame_q, frame_d;
    hist_snap_t        pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    hist_idx_t         idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    hist_idx_t         m_idx_q, m_idx_d;
    logic              m_last_q, m_last_d;
    logic              xfer_c, final_c, send_c;

    assign hist_c  = {hist_3, hist_2, hist_1, hist_0};
    assign valid_c = {hist_valid_3, hist_valid_2, hist_valid_1, hist_valid_0};

    hist_snapshot_capture #(
        .DATA_W (DATA_W)
    ) u_capture (
        .clk_i    (clk_in),
        .rst_n_i  (reset_n_in),
        .hist_i   (hist_c),
        .valid_i  (valid_c),
        .evt_c_o  (evt_c),
        .snap_c_o (snap_c)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            idx_q      <= '0;
            drop_q     <= '0;
            m_data_q   <= '0;
            m_idx_q    <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            m_data_q   <= m_data_d;
            m_idx_q    <= m_idx_d;
            m_last_q   <= m_last_d;
        end
    end

    // Frame sequencing, pending hand-off and beat output staging.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        xfer_c     = (state_q == ST_SEND) && m_ready;
        final_c    = xfer_c && (CNT_W'(idx_q) == frame_q.cnt - CNT_W'(1));

        unique case (state_q)
            ST_IDLE: begin
                if (evt_c) begin
                    frame_d = snap_c;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (final_c) begin
                    idx_d = '0;
                    if (pend_vld_q) begin
                        // A coincident event refills pending without a drop.
                        frame_d    = pend_q;
                        pend_d     = snap_c;
                        pend_vld_d = evt_c;
                    end else if (evt_c) begin
                        frame_d = snap_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (xfer_c) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (evt_c) begin
                        if (pend_vld_q && (drop_q != {DROP_W{1'b1}})) begin
                            drop_d = drop_q + DROP_W'(1);
                        end
                        pend_d     = snap_c;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        send_c   = (state_d == ST_SEND);
        m_idx_d  = send_c ? idx_d : '0;
        m_data_d = send_c ? DATA_W'(frame_d.vals[idx_d]) : '0;
        m_last_d = send_c && (CNT_W'(idx_d) == frame_d.cnt - CNT_W'(1));
    end

    assign m_data       = m_data_q;
    assign m_idx        = m_idx_q;
    assign m_last       = m_last_q;
    assign m_valid      = (state_q == ST_SEND);
    assign busy_out     = (state_q == ST_SEND);
    assign drop_cnt_out = drop_q;

endmodule

// File: doc/history_serializer.md
HISTORY_SERIALIZER -- requirements
Module: history_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of every history entry.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports hist_0..hist_3, input, DATA_W each: distinct-value history from the upstream tracker, where hist_0 is the newest entry.
REQ-005 The block SHALL have ports hist_valid_0..hist_valid_3, input, 1 bit each: validity of the matching hist_k.
REQ-006 The block SHALL have port m_data, output, DATA_W: the current beat's entry value.
REQ-007 The block SHALL have port m_idx, output, 2 bits: the history index k of the current beat.
REQ-008 The block SHALL have port m_last, output, 1 bit: marks the final beat of a frame.
REQ-009 The block SHALL have ports m_valid, output, 1 bit, and m_ready, input, 1 bit: the beat handshake; a beat transfers on a rising edge with m_valid=1 and m_ready=1.
REQ-010 The block SHALL have port busy_out, output, 1 bit: high while a frame is in flight.
REQ-011 The block SHALL have port drop_cnt_out, output, 8 bits: saturating count of overwritten pending snapshots.

Function
REQ-012 The block SHALL register the inputs each cycle into snap_prev (all 4x(DATA_W+1) bits); an event occurs when the live inputs differ from snap_prev in any bit.
REQ-013 A snapshot SHALL have count n equal to the index of the first deasserted hist_valid_k, or 4 if all are set; non-contiguous valids beyond the first zero SHALL be ignored.
REQ-014 A snapshot with n=0 SHALL be discarded, without creating a frame, a pending entry or a drop.
REQ-015 The FSM SHALL have two states, ST_IDLE and ST_SEND.
REQ-016 In ST_IDLE, an event SHALL load the snapshot into the frame buffer and enter ST_SEND, with m_valid=1, m_idx=0 and m_data=hist_0 visible in the following cycle (1-cycle latency).
REQ-017 In ST_SEND, beats SHALL be emitted in order for k=0..n-1, with m_last=1 only on k=n-1.
REQ-018 While m_valid=1 and m_ready=0, m_data, m_idx and m_last SHALL hold stable; m_valid SHALL NOT drop before the transfer.
REQ-019 An event in ST_SEND SHALL store the snapshot in a one-deep pending register, with the newest snapshot overwriting the pending one.
REQ-020 Overwriting an occupied pending register SHALL increment drop_cnt_out, saturating at 255.
REQ-021 On the final beat's transfer with pending occupied, the pending snapshot SHALL become the next frame with no idle cycle (k=0 in the next cycle).
REQ-022 On the final beat's transfer with pending empty, the FSM SHALL return to ST_IDLE and m_valid SHALL drop in the next cycle.
REQ-023 An event coincident with the final-beat transfer SHALL proceed as follows:
- pending empty: the event snapshot becomes the next frame directly.
- pending occupied: pending becomes the frame and the event snapshot becomes the new pending, with no drop counted.
REQ-024 busy_out SHALL equal (state==ST_SEND).

Reset
REQ-025 While reset_n_in=0, the following SHALL be 0 asynchronously: m_valid, m_data, m_idx, m_last, busy_out, drop_cnt_out, the pending flag, snap_prev and the frame buffer; state SHALL be ST_IDLE.
REQ-026 Reset assertion mid-frame SHALL abort the frame; after release no partial frame SHALL resume, and the first event is judged against all-zero snap_prev.

Structure
REQ-027 A shared package history_pkg SHALL hold HIST_DEPTH=4, the 2-bit index typedef, the snapshot struct (values plus count) and the state enum.
REQ-028 One sub-module, hist_snapshot_capture, SHALL hold snap_prev, event detection and count computation.

Verification
REQ-029 Reset, then hist_0=0x11 with valid_0=1, m_ready=1 -> one beat (0x11, idx 0, last=1), 1 cycle after sampling.
REQ-030 All four entries valid (0x44, 0x33, 0x22, 0x11) with m_ready toggling 1/0 -> beats in order 0x44..0x11, stable while stalled, last only on 0x11.
REQ-031 valid=1,1,0,1 -> n=2; only idx 0 and 1 are emitted.
REQ-032 m_ready=0 during a frame, then three events A, B, C -> drop_cnt_out=2; after the frame, snapshot C is sent back-to-back with no idle cycle.
REQ-033 Event coincident with the final-beat transfer, pending empty -> new frame k=0 in the next cycle, and drop_cnt_out is unchanged.
REQ-034 reset_n_in pulsed low during beat idx 1 -> outputs are immediately 0; after release with static inputs 0x55/valid_0=1, one frame (0x55) is emitted.
